id_stage_qdec: RTL

- Parametrised successor of the single-instruction decode stage.
- Adds an N-entry instruction queue between the Icache return path and decode. Flushes generalise the single-cycle kill into a configurable kill window.
- Decoded operands and immediate are registered into an output stage with valid/ready handshake toward EX.
- JAL/JALR resolve locally and redirect fetch.
- Sits between Icache/fc and id_ex_reg. Keeps the regs and dhnf interfaces of the existing decode stage.

---
 rtl/id_stage_qdec_pkg.sv | 40 ++++
 rtl/id_stage_qdec_imm_gen.sv | 23 ++
 rtl/id_stage_qdec.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_qdec_pkg.sv
// Shared decode constants for the queued decode stage and the immediate generator.
// Also holds the opcode-to-immediate-format mapping.
package id_stage_qdec_pkg;

  localparam logic [6:0] Btype   = 7'b1100011;
  localparam logic [6:0] Itype_A = 7'b0010011;
  localparam logic [6:0] Itype_J = 7'b1100111;
  localparam logic [6:0] Jtype_J = 7'b1101111;
  localparam logic [6:0] Utype_L = 7'b0110111;
  localparam logic [6:0] Utype_A = 7'b0010111;
  localparam logic [6:0] Stype   = 7'b0100011;
  localparam logic [6:0] Ltype   = 7'b0000011;
  localparam logic [6:0] Rtype   = 7'b0110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      Itype_A, Itype_J, Ltype: fmt = IMM_I;
      Stype:                   fmt = IMM_S;
      Btype:                   fmt = IMM_B;
      Utype_L, Utype_A:        fmt = IMM_U;
      Jtype_J:                 fmt = IMM_J;
      default:                 fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/id_stage_qdec_imm_gen.sv
// Combinational RV32I immediate generator; R-type and unknown opcodes yield zero.
// Shared with the EX-side branch unit.
module id_imm_gen
  import id_stage_qdec_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);

  // Sign-extend the immediate according to the instruction format
  always_comb begin
    imm_o = 32'h0;
    case (imm_fmt(inst_i[6:0]))
      IMM_I:   imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      IMM_U:   imm_o = {inst_i[31:12], 12'h000};
      IMM_J:   imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/id_stage_qdec.sv
// Decode stage with an instruction queue, kill window after redirects,
// registered operand output stage and local JAL/JALR resolution.
module id_stage_qdec
  import id_stage_qdec_pkg::*;
#(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned KILL_CYCLES = 1,
  parameter logic [31:0] PC_RESET    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Icache_inst_i,
  input  logic [31:0] Icache_pc_i,
  input  logic        fc_Icache_data_valid_i,
  output logic        id_ready_o,
  input  logic        fc_flush_i,
  output logic [4:0]  id_reg1_raddr_o,
  output logic [4:0]  id_reg2_raddr_o,
  output logic        id_reg1_RE_o,
  output logic        id_reg2_RE_o,
  input  logic [31:0] regs_reg1_rdata_i,
  input  logic [31:0] regs_reg2_rdata_i,
  input  logic        dhnf_harzard_sel1_i,
  input  logic        dhnf_harzard_sel2_i,
  input  logic [31:0] dhnf_forward_data1_i,
  input  logic [31:0] dhnf_forward_data2_i,
  input  logic        dhnf_stall_i,
  input  logic        ex_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_op_a_o,
  output logic [31:0] id_op_b_o,
  output logic [31:0] id_imm_o,
  output logic [31:0] id_mem_wr_data_o,
  output logic        id_jump_flag_o,
  output logic [31:0] id_jump_pc_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned KIL_W = $clog2(KILL_CYCLES + 2);

  logic [31:0]      pc_mem_q [QDEPTH];
  logic [31:0]      pc_mem_d [QDEPTH];
  logic [31:0]      inst_mem_q [QDEPTH];
  logic [31:0]      inst_mem_d [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KIL_W-1:0] kill_q, kill_d;

  logic        valid_q, valid_d, jump_flag_q, jump_flag_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] imm_q, imm_d, mem_wr_data_q, mem_wr_data_d, jump_pc_q, jump_pc_d;

  logic [31:0] head_pc_s, head_inst_s, head_imm_s, rs1_fwd_s, rs2_fwd_s;
  logic [31:0] op_a_s, op_b_s, jump_pc_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  imm_fmt_e    fmt_s;
  logic        head_valid_s, accept_s, issue_s, is_jump_s, jump_s, push_s;
  logic        reg1_re_s, reg2_re_s;

  assign head_pc_s    = pc_mem_q[rd_ptr_q];
  assign head_inst_s  = inst_mem_q[rd_ptr_q];
  assign opcode_s     = head_inst_s[6:0];
  assign funct3_s     = head_inst_s[14:12];
  assign fmt_s        = imm_fmt(opcode_s);
  assign head_valid_s = (cnt_q != '0);
  assign rs1_fwd_s    = dhnf_harzard_sel1_i ? dhnf_forward_data1_i : regs_reg1_rdata_i;
  assign rs2_fwd_s    = dhnf_harzard_sel2_i ? dhnf_forward_data2_i : regs_reg2_rdata_i;

  id_imm_gen u_imm_gen (
    .inst_i (head_inst_s),
    .imm_o  (head_imm_s)
  );

  assign id_ready_o = (cnt_q < CNT_W'(QDEPTH));
  assign accept_s   = ex_ready_i | ~valid_q;
  assign issue_s    = head_valid_s & ~dhnf_stall_i & accept_s;
  assign is_jump_s  = (opcode_s == Jtype_J) | (opcode_s == Itype_J);
  assign jump_s     = issue_s & is_jump_s;
  assign push_s     = fc_Icache_data_valid_i & id_ready_o & (kill_q == '0) & ~fc_flush_i;

  // Register-file read enables for the queue head
  always_comb begin
    reg1_re_s = 1'b0;
    reg2_re_s = 1'b0;
    case (opcode_s)
      Rtype, Btype, Stype: begin
        reg1_re_s = 1'b1;
        reg2_re_s = 1'b1;
      end
      Itype_A, Itype_J, Ltype: reg1_re_s = 1'b1;
      default: begin
        reg1_re_s = 1'b0;
        reg2_re_s = 1'b0;
      end
    endcase
  end

  assign id_reg1_raddr_o = head_inst_s[19:15];
  assign id_reg2_raddr_o = head_inst_s[24:20];
  assign id_reg1_RE_o    = reg1_re_s;
  assign id_reg2_RE_o    = reg2_re_s;

  // Operand selection and local jump target for the queue head
  always_comb begin
    op_a_s = rs1_fwd_s;
    case (opcode_s)
      Utype_L:                   op_a_s = 32'h0;
      Utype_A, Jtype_J, Itype_J: op_a_s = head_pc_s;
      default:                   op_a_s = rs1_fwd_s;
    endcase
    op_b_s = rs2_fwd_s;
    if (is_jump_s) begin
      op_b_s = 32'd4;
    end else if ((opcode_s == Itype_A) && ((funct3_s == F3_SLLI) || (funct3_s == F3_SRXI))) begin
      op_b_s = {27'h0, head_inst_s[24:20]};
    end else if ((fmt_s == IMM_I) || (fmt_s == IMM_S) || (fmt_s == IMM_U)) begin
      op_b_s = head_imm_s;
    end else begin
      op_b_s = rs2_fwd_s;
    end
    if (opcode_s == Itype_J) begin
      jump_pc_s = (rs1_fwd_s + head_imm_s) & ~32'h1;
    end else begin
      jump_pc_s = head_pc_s + head_imm_s;
    end
  end

  // Queue pointers, occupancy and kill window; redirects discard everything queued
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (kill_q != '0) begin
      kill_d = kill_q - KIL_W'(1);
    end else begin
      kill_d = kill_q;
    end
    if (fc_flush_i || jump_s) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      kill_d   = KIL_W'(KILL_CYCLES);
    end else begin
      if (push_s) begin
        pc_mem_d[wr_ptr_q]   = Icache_pc_i;
        inst_mem_d[wr_ptr_q] = Icache_inst_i;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, issue_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Output stage: flush clears, issue loads, accepted-but-idle inserts a bubble
  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    imm_d         = imm_q;
    mem_wr_data_d = mem_wr_data_q;
    jump_pc_d     = jump_pc_q;
    jump_flag_d   = 1'b0;
    if (fc_flush_i) begin
      valid_d = 1'b0;
    end else if (issue_s) begin
      valid_d       = 1'b1;
      pc_d          = head_pc_s;
      inst_d        = head_inst_s;
      op_a_d        = op_a_s;
      op_b_d        = op_b_s;
      imm_d         = head_imm_s;
      mem_wr_data_d = rs2_fwd_s;
      jump_flag_d   = is_jump_s;
      jump_pc_d     = is_jump_s ? jump_pc_s : jump_pc_q;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mem_q      <= '{default: 32'h0};
      inst_mem_q    <= '{default: 32'h0};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      kill_q        <= '0;
      valid_q       <= 1'b0;
      pc_q          <= PC_RESET;
      inst_q        <= 32'h0;
      op_a_q        <= 32'h0;
      op_b_q        <= 32'h0;
      imm_q         <= 32'h0;
      mem_wr_data_q <= 32'h0;
      jump_flag_q   <= 1'b0;
      jump_pc_q     <= 32'h0;
    end else begin
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      kill_q        <= kill_d;
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      imm_q         <= imm_d;
      mem_wr_data_q <= mem_wr_data_d;
      jump_flag_q   <= jump_flag_d;
      jump_pc_q     <= jump_pc_d;
    end
  end

  assign id_valid_o       = valid_q;
  assign id_pc_o          = pc_q;
  assign id_inst_o        = inst_q;
  assign id_op_a_o        = op_a_q;
  assign id_op_b_o        = op_b_q;
  assign id_imm_o         = imm_q;
  assign id_mem_wr_data_o = mem_wr_data_q;
  assign id_jump_flag_o   = jump_flag_q;
  assign id_jump_pc_o     = jump_pc_q;

endmodule
